fetch_arb: RTL
==============

FETCH_ARB -- requirements
Module: fetch_arb

Interface
REQ-001 Parameter addr_width, default 32, byte address width.
REQ-002 Parameter list_depth, default 4, number of cache lines; tag width TW = $clog2(list_depth).
REQ-003 Parameter timeout_cycles, default 1024, maximum WAIT_DONE dwell before error; minimum 2.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 rd_fetch_req / rd_fetch_cmd / rd_fetch_tag / rd_fetch_addr  input  1 / 2 / TW / addr_width  read-controller fetch request and payload.
REQ-007 rd_fetch_gnt  output  1  grant to the read controller; rd_fetch_done  output  1  completion pulse to the read controller.
REQ-008 wr_fetch_req / wr_fetch_cmd / wr_fetch_tag / wr_fetch_addr  input  1 / 2 / TW / addr_width  write-controller fetch request and payload.
REQ-009 wr_fetch_gnt  output  1  grant to the write controller; wr_fetch_done  output  1  completion pulse to the write controller.
REQ-010 fetch_req / fetch_cmd / fetch_tag / fetch_addr  output  1 / 2 / TW / addr_width  request and payload to the shared fetch engine.
REQ-011 fetch_gnt  input  1  engine accepts the request; fetch_done  input  1  engine completion pulse.
REQ-012 timeout_err  output  1  sticky watchdog error.

Function
REQ-013 The block SHALL be a 3-state FSM with states IDLE, ISSUE and WAIT_DONE, plus a 1-bit owner register (0 = rd, 1 = wr) and a 1-bit round-robin pointer rr (0 = rd preferred).
REQ-014 In IDLE with exactly one request asserted, the block SHALL latch that requester as owner and go to ISSUE on the next edge.
REQ-015 In IDLE with both requests asserted, the block SHALL select the requester indicated by rr.
REQ-016 In IDLE with no request asserted, the block SHALL remain in IDLE.
REQ-017 In ISSUE, fetch_req SHALL equal the owner's request, and fetch_cmd/tag/addr SHALL equal the owner's payload, passed through combinationally.
REQ-018 In ISSUE, the owner's gnt SHALL equal fetch_gnt; the non-owner's gnt SHALL be 0.
REQ-019 Request-to-engine latency SHALL be 1 cycle: a request sampled in IDLE at edge N appears on fetch_req during cycle N+1.
REQ-020 In ISSUE, on fetch_req && fetch_gnt, the block SHALL go to WAIT_DONE.
REQ-021 In ISSUE, if the owner deasserts its request before grant, the block SHALL return to IDLE without updating rr.
REQ-022 In WAIT_DONE, fetch_req SHALL be 0.
REQ-023 In WAIT_DONE, fetch_done SHALL be routed to the owner's done output in the same cycle, combinationally; the non-owner's done SHALL be 0.
REQ-024 On fetch_done in WAIT_DONE, the block SHALL go to IDLE and set rr to the inverse of owner.
REQ-025 fetch_done outside WAIT_DONE SHALL be ignored: no done output, no state change.
REQ-026 fetch_gnt outside ISSUE SHALL be ignored.
REQ-027 Outside ISSUE, fetch_cmd/tag/addr SHALL be 0.
REQ-028 A 32-bit wait counter SHALL clear on entry to WAIT_DONE and increment each WAIT_DONE cycle, saturating at all-ones.
REQ-029 When the counter reaches timeout_cycles, timeout_err SHALL set and hold until reset; the FSM SHALL keep waiting for fetch_done.
REQ-030 At most one fetch SHALL be outstanding at the engine at any time.
REQ-031 A requester that reasserts its request in the same cycle its done pulses SHALL be arbitrated in IDLE on the next cycle, with rr favouring the other requester.

Reset
REQ-032 On rst_n low, at any point including mid-transaction, the block SHALL enter IDLE and set owner = 0, rr = 0, counter = 0 and timeout_err = 0.
REQ-033 While reset is asserted, all outputs SHALL be 0.
REQ-034 An engine done arriving after reset releases SHALL be discarded per REQ-025.

Verification
REQ-035 rd_fetch_req=1 alone, rd_fetch_addr=0x1000, tag=2, fetch_gnt tied 1 -> next cycle fetch_req=1, fetch_addr=0x1000, fetch_tag=2, rd_fetch_gnt=1; fetch_done 5 cycles later -> rd_fetch_done=1 for 1 cycle, state IDLE.
REQ-036 Both requests held continuously from reset, engine completing each fetch -> grants alternate rd, wr, rd, wr; rr=1 after the first completion.
REQ-037 Owner in WAIT_DONE, other requester asserts -> other's gnt stays 0 and fetch_req stays 0 until the done pulse, then the other requester is issued 1 cycle later.
REQ-038 timeout_cycles=8, engine never returns done -> timeout_err=1 exactly 8 cycles after entering WAIT_DONE, remaining 1 after a later fetch_done.
REQ-039 rst_n pulsed low during WAIT_DONE, then fetch_done arrives -> no done outputs, state IDLE, timeout_err=0.
REQ-040 wr request dropped in ISSUE before fetch_gnt -> return to IDLE, no wr_fetch_gnt, rr unchanged.

Source files
------------

// File: rtl/fetch_arb.sv
// fetch_arb: two-requester round-robin arbiter in front of a single shared
// fetch engine. One fetch outstanding at a time; sticky watchdog on completion.
module fetch_arb #(
    parameter int unsigned addr_width     = 32,
    parameter int unsigned list_depth     = 4,
    parameter int unsigned timeout_cycles = 1024
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           rd_fetch_req,
    input  logic [1:0]                                     rd_fetch_cmd,
    input  logic [((list_depth > 1) ? $clog2(list_depth) : 1)-1:0] rd_fetch_tag,
    input  logic [addr_width-1:0]                          rd_fetch_addr,
    output logic                                           rd_fetch_gnt,
    output logic                                           rd_fetch_done,
    input  logic                                           wr_fetch_req,
    input  logic [1:0]                                     wr_fetch_cmd,
    input  logic [((list_depth > 1) ? $clog2(list_depth) : 1)-1:0] wr_fetch_tag,
    input  logic [addr_width-1:0]                          wr_fetch_addr,
    output logic                                           wr_fetch_gnt,
    output logic                                           wr_fetch_done,
    output logic                                           fetch_req,
    output logic [1:0]                                     fetch_cmd,
    output logic [((list_depth > 1) ? $clog2(list_depth) : 1)-1:0] fetch_tag,
    output logic [addr_width-1:0]                          fetch_addr,
    input  logic                                           fetch_gnt,
    input  logic                                           fetch_done,
    output logic                                           timeout_err
);

    localparam int unsigned TW = (list_depth > 1) ? $clog2(list_depth) : 1;
    localparam int unsigned CW = 32;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] TIMEOUT = CW'(timeout_cycles);

    logic [1:0]    state_q, state_d;
    logic          owner_q, owner_d;   // 0 = rd, 1 = wr
    logic          rr_q, rr_d;         // 0 = rd preferred on contention
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          own_req;

    // Request of the current owner
    always_comb begin
        own_req = owner_q ? wr_fetch_req : rd_fetch_req;
    end

    // State, owner, round-robin pointer, wait counter and watchdog registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state: arbitration, issue handshake, completion and watchdog
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (rd_fetch_req || wr_fetch_req) begin
                    state_d = ISSUE;
                    owner_d = (rd_fetch_req && wr_fetch_req) ? rr_q : wr_fetch_req;
                end
            end
            ISSUE: begin
                if (own_req && fetch_gnt) begin
                    state_d = WAIT_DONE;
                    cnt_d   = '0;
                end else if (!own_req) begin
                    // Requester withdrew before acceptance; pointer stays put
                    state_d = IDLE;
                end
            end
            WAIT_DONE: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (cnt_d == TIMEOUT) begin
                    err_d = 1'b1;
                end
                if (fetch_done) begin
                    state_d = IDLE;
                    rr_d    = ~owner_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Combinational routing of request/payload/grant/done by state and owner
    always_comb begin
        fetch_req     = 1'b0;
        fetch_cmd     = '0;
        fetch_tag     = '0;
        fetch_addr    = '0;
        rd_fetch_gnt  = 1'b0;
        wr_fetch_gnt  = 1'b0;
        rd_fetch_done = 1'b0;
        wr_fetch_done = 1'b0;
        case (state_q)
            ISSUE: begin
                fetch_req = own_req;
                if (owner_q) begin
                    fetch_cmd  = wr_fetch_cmd;
                    fetch_tag  = TW'(wr_fetch_tag);
                    fetch_addr = wr_fetch_addr;
                end else begin
                    fetch_cmd  = rd_fetch_cmd;
                    fetch_tag  = TW'(rd_fetch_tag);
                    fetch_addr = rd_fetch_addr;
                end
                rd_fetch_gnt = ~owner_q & rd_fetch_req & fetch_gnt;
                wr_fetch_gnt =  owner_q & wr_fetch_req & fetch_gnt;
            end
            WAIT_DONE: begin
                rd_fetch_done = ~owner_q & fetch_done;
                wr_fetch_done =  owner_q & fetch_done;
            end
            default: begin
            end
        endcase
    end

    assign timeout_err = err_q;

endmodule
